// File: rtl/cmul_round_clip.sv
// cmul_round_clip
// Requantises the full-precision complex-multiplier output to sc16.
// Each 32-bit component is arithmetic-shifted right by a run-time amount,
// rounded half-to-even, and saturated to 16 bits. The block is a
// two-stage AXI-Stream pipeline with tlast carried alongside each sample.
//
// Optional build macro: CMUL_RC_SAT_COUNT_EN
//   When defined, sat_cnt counts output beats whose I or Q component was
//   clipped. The count saturates at all-ones and is cleared by sat_clr.
//   When undefined, sat_clr is ignored and sat_cnt is tied to zero.
//
// Ports:
//   clk       clock
//   reset     asynchronous active-high reset
//   shift     right-shift amount (0..16; 17..31 are treated as 16)
//   i_tdata   {I[31:0], Q[31:0]} signed input sample
//   i_tlast   input end of packet
//   i_tvalid  input valid
//   i_tready  input ready
//   o_tdata   {I[15:0], Q[15:0]} signed output sample
//   o_tlast   output end of packet
//   o_tvalid  output valid
//   o_tready  output ready
//   sat_clr   synchronous clear of the saturation counter
//   sat_cnt   number of clipped output beats
module cmul_round_clip #(
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           shift,
  input  logic [63:0]          i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [31:0]          o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  localparam int DATA_W = 32;
  localparam int OUT_W  = 16;

  // Arithmetic shift right by s with round-half-to-even on the dropped bits.
  // s is already clamped to 0..16, so the rounding add cannot overflow.
  function automatic logic signed [DATA_W-1:0] round_shift(
    input logic signed [DATA_W-1:0] x,
    input logic [4:0]               s
  );
    logic signed [DATA_W-1:0] f;
    logic [DATA_W-1:0]        mask;
    logic                     g;
    logic                     k;
    if (s == 5'd0) begin
      return x;
    end
    f    = x >>> s;
    g    = x[s - 5'd1];
    mask = (DATA_W'(1) << (s - 5'd1)) - DATA_W'(1);
    k    = |($unsigned(x) & mask);
    return f + {{(DATA_W-1){1'b0}}, g & (k | f[0])};
  endfunction

  // Saturate to 16 bits; the MSB of the result is the clip flag.
  function automatic logic [OUT_W:0] sat16(input logic signed [DATA_W-1:0] r);
    if (r > 32'sd32767) begin
      return {1'b1, 16'h7FFF};
    end
    if (r < -32'sd32768) begin
      return {1'b1, 16'h8000};
    end
    return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic                     e1;
  logic                     e2;
  logic [4:0]               s_eff;
  logic signed [DATA_W-1:0] in_i;
  logic signed [DATA_W-1:0] in_q;

  logic                     vld_p1;
  logic                     last_p1;
  logic signed [DATA_W-1:0] rnd_i_p1;
  logic signed [DATA_W-1:0] rnd_q_p1;

  logic                     vld_p2;
  logic                     last_p2;
  logic                     clip_p2;
  logic [2*OUT_W-1:0]       dat_p2;

  logic [OUT_W:0]           sat_i;
  logic [OUT_W:0]           sat_q;

  // An empty stage always accepts, so bubbles collapse under backpressure.
  assign e2       = ~vld_p2 | o_tready;
  assign e1       = ~vld_p1 | e2;
  assign i_tready = e1;

  assign s_eff = (shift > 5'd16) ? 5'd16 : shift;
  assign in_i  = $signed(i_tdata[63:32]);
  assign in_q  = $signed(i_tdata[31:0]);

  // ---- stage 1: shift and round (shift captured with the sample) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (e1) begin
      vld_p1 <= i_tvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (e1 && i_tvalid) begin
      rnd_i_p1 <= round_shift(in_i, s_eff);
      rnd_q_p1 <= round_shift(in_q, s_eff);
      last_p1  <= i_tlast;
    end
  end

  // ---- stage 2: saturate to sc16 and flag clipping ----
  assign sat_i = sat16(rnd_i_p1);
  assign sat_q = sat16(rnd_q_p1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      dat_p2  <= '0;
      last_p2 <= 1'b0;
      clip_p2 <= 1'b0;
    end else if (e2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        dat_p2  <= {sat_i[OUT_W-1:0], sat_q[OUT_W-1:0]};
        last_p2 <= last_p1;
        clip_p2 <= sat_i[OUT_W] | sat_q[OUT_W];
      end
    end
  end

  assign o_tvalid = vld_p2;
  assign o_tdata  = dat_p2;
  assign o_tlast  = last_p2;

  // ---- saturation event counter (output handshake side) ----
`ifdef CMUL_RC_SAT_COUNT_EN
  logic [SAT_CNT_W-1:0] sat_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_cnt_q <= '0;
    end else if (sat_clr) begin
      sat_cnt_q <= '0;
    end else if (vld_p2 && o_tready && clip_p2 && (sat_cnt_q != '1)) begin
      sat_cnt_q <= sat_cnt_q + SAT_CNT_W'(1);
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic sat_unused;

  assign sat_unused = sat_clr | clip_p2;
  assign sat_cnt    = '0;
`endif

endmodule
